// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_pkg
// Description : Constants and state type shared by the PWM duty path.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    localparam int DUTY_W   = 4;
    localparam int DUTY_MAX = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/pwm_step_timer.sv
`default_nettype none
// ============================================================================
// Module      : pwm_step_timer
// Description : Counts PWM period starts and flags every STEP_PERIODS-th one.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_step_timer #(
    parameter int STEP_PERIODS = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic period_start,
    output logic step_tick
);

    localparam int                CNT_W  = $clog2(STEP_PERIODS + 1);
    localparam logic [CNT_W-1:0]  c_last = CNT_W'(STEP_PERIODS - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_at_last;

    assign w_at_last = (r_count == c_last);
    // A clear in the same cycle suppresses the tick so an abort can never step.
    assign step_tick = period_start & w_at_last & ~clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (period_start) begin
            if (w_at_last) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pwm_duty_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pwm_duty_sequencer
// Description : Ramps the PWM duty toward a commanded target on period edges,
//               with manual single-step buttons while idle.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_duty_sequencer
    import pwm_pkg::*;
#(
    parameter int DUTY_W       = pwm_pkg::DUTY_W,
    parameter int DUTY_MAX     = pwm_pkg::DUTY_MAX,
    parameter int INIT_DUTY    = 5,
    parameter int STEP_PERIODS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              period_start,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DUTY_W-1:0] cmd_target,
    input  logic              abort,
    input  logic              btn_inc,
    input  logic              btn_dec,
    output logic [DUTY_W-1:0] duty_out,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [DUTY_W-1:0] c_duty_max  = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W-1:0] c_init_duty = DUTY_W'(INIT_DUTY);

    seq_state_t        r_state;
    logic [DUTY_W-1:0] r_duty;
    logic [DUTY_W-1:0] r_target;
    logic              r_done;
    logic              r_err;

    logic              w_handshake;
    logic              w_step_tick;
    logic              w_timer_clear;
    logic [DUTY_W-1:0] w_duty_inc;
    logic [DUTY_W-1:0] w_duty_dec;
    logic [DUTY_W-1:0] w_duty_step;

    assign cmd_ready     = (r_state == IDLE);
    assign busy          = (r_state != IDLE);
    assign duty_out      = r_duty;
    assign done          = r_done;
    assign err           = r_err;

    assign w_handshake   = cmd_valid & cmd_ready;
    assign w_timer_clear = (r_state == IDLE) | abort;
    assign w_duty_inc    = r_duty + DUTY_W'(1);
    assign w_duty_dec    = r_duty - DUTY_W'(1);
    assign w_duty_step   = (r_state == UP) ? w_duty_inc : w_duty_dec;

    pwm_step_timer #(
        .STEP_PERIODS (STEP_PERIODS)
    ) u_step_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (w_timer_clear),
        .period_start (period_start),
        .step_tick    (w_step_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_duty   <= c_init_duty;
            r_target <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_handshake) begin
                        r_target <= cmd_target;
                        if (cmd_target > c_duty_max) begin
                            r_err <= 1'b1;
                        end else if (cmd_target == r_duty) begin
                            r_done <= 1'b1;
                        end else if (cmd_target > r_duty) begin
                            r_state <= UP;
                        end else begin
                            r_state <= DOWN;
                        end
                    end else if (btn_inc && !btn_dec) begin
                        if (r_duty < c_duty_max) begin
                            r_duty <= w_duty_inc;
                        end
                    end else if (btn_dec && !btn_inc) begin
                        if (r_duty != '0) begin
                            r_duty <= w_duty_dec;
                        end
                    end
                end
                UP, DOWN: begin
                    if (abort) begin
                        r_state <= IDLE;
                    end else if (w_step_tick) begin
                        // done is raised in the same cycle the final duty lands
                        r_duty <= w_duty_step;
                        if (w_duty_step == r_target) begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_duty_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_duty_sequencer
// Description : Randomized and directed bench for pwm_duty_sequencer with an
//               event scoreboard fed by a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_duty_sequencer;

    localparam int DUTY_W       = 4;
    localparam int DUTY_MAX     = 10;
    localparam int INIT_DUTY    = 5;
    localparam int STEP_PERIODS = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              period_start = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [DUTY_W-1:0] cmd_target = '0;
    logic              abort = 1'b0;
    logic              btn_inc = 1'b0;
    logic              btn_dec = 1'b0;
    logic [DUTY_W-1:0] duty_out;
    logic              busy;
    logic              done;
    logic              err;

    pwm_duty_sequencer #(
        .DUTY_W       (DUTY_W),
        .DUTY_MAX     (DUTY_MAX),
        .INIT_DUTY    (INIT_DUTY),
        .STEP_PERIODS (STEP_PERIODS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .period_start (period_start),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_target   (cmd_target),
        .abort        (abort),
        .btn_inc      (btn_inc),
        .btn_dec      (btn_dec),
        .duty_out     (duty_out),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int duty;
        bit done;
        bit err;
    } ev_t;

    ev_t         exp_q[$];
    int          m_duty   = INIT_DUTY;
    bit          m_ramp   = 1'b0;
    int          m_tgt    = 0;
    int          m_pulses = 0;
    int          ptick    = 0;
    int          timeouts = 0;
    bit          finish_req = 1'b0;
    int          total = 0;
    int          bad   = 0;
    logic [DUTY_W-1:0] prev_duty = '0;

    // Reference: a ramp moves one code toward the target on every
    // STEP_PERIODS-th period start counted since the command was accepted.
    task automatic model(input bit ps, input bit cv, input int tg,
                         input bit ab, input bit bi, input bit bd);
        int old;
        ev_t e;
        old    = m_duty;
        e.done = 1'b0;
        e.err  = 1'b0;
        if (!m_ramp) begin
            if (cv) begin
                if (tg > DUTY_MAX) e.err = 1'b1;
                else if (tg == m_duty) e.done = 1'b1;
                else begin
                    m_ramp = 1'b1;
                    m_tgt = tg;
                    m_pulses = 0;
                end
            end else if (bi && !bd) begin
                m_duty = (m_duty >= DUTY_MAX) ? m_duty : m_duty + 1;
            end else if (bd && !bi) begin
                m_duty = (m_duty == 0) ? 0 : m_duty - 1;
            end
        end else if (ab) begin
            m_ramp = 1'b0;
        end else if (ps) begin
            m_pulses++;
            if (m_pulses % STEP_PERIODS == 0) begin
                m_duty = (m_tgt > m_duty) ? m_duty + 1 : m_duty - 1;
                if (m_duty == m_tgt) begin
                    m_ramp = 1'b0;
                    e.done = 1'b1;
                end
            end
        end
        e.duty = m_duty;
        if (m_duty != old || e.done || e.err) exp_q.push_back(e);
    endtask

    task automatic cyc(input bit ps, input bit cv, input int tg,
                       input bit ab, input bit bi, input bit bd);
        period_start = ps;
        cmd_valid    = cv;
        cmd_target   = 4'(tg);
        abort        = ab;
        btn_inc      = bi;
        btn_dec      = bd;
        @(posedge clk);
        model(ps, cv, tg, ab, bi, bd);
        #1;
        period_start = 1'b0;
        cmd_valid    = 1'b0;
        abort        = 1'b0;
        btn_inc      = 1'b0;
        btn_dec      = 1'b0;
    endtask

    function automatic bit next_ps();
        bit r;
        r = (ptick == 9);
        ptick = (ptick + 1) % 10;
        return r;
    endfunction

    task automatic tick(input bit cv, input int tg, input bit ab, input bit bi, input bit bd);
        bit ps;
        ps = next_ps();
        cyc(ps, cv, tg, ab, bi, bd);
    endtask

    task automatic run_idle(input int budget);
        int n;
        n = 0;
        while (m_ramp && n < budget) begin
            tick(0, 0, 0, 0, 0);
            n++;
        end
        if (m_ramp) begin
            $display("FAIL ramp_timeout busy still expected after %0d cycles, required return to idle", budget);
            timeouts++;
        end
    endtask

    task automatic abort_at_pulse(input int pulse_no, input int budget);
        int n;
        bit ps;
        n = 0;
        while (m_ramp && n < budget) begin
            ps = next_ps();
            cyc(ps, 0, 0, ps && (m_pulses == pulse_no - 1), 0, 0);
            n++;
        end
        if (m_ramp) begin
            $display("FAIL abort_timeout ramp still expected after %0d cycles, required abort", budget);
            timeouts++;
        end
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (!rst_n) begin
            total++;
            if (duty_out !== 4'(INIT_DUTY) || busy !== 1'b0 || cmd_ready !== 1'b1 ||
                done !== 1'b0 || err !== 1'b0) begin
                bad++;
                $display("FAIL reset_state duty=%0d busy=%b ready=%b done=%b err=%b, required duty=%0d busy=0 ready=1 done=0 err=0",
                         duty_out, busy, cmd_ready, done, err, INIT_DUTY);
            end
            prev_duty = duty_out;
        end else begin
            total++;
            if (busy !== m_ramp || cmd_ready !== !m_ramp) begin
                bad++;
                $display("FAIL busy_ready busy=%b ready=%b, required busy=%b ready=%b",
                         busy, cmd_ready, m_ramp, !m_ramp);
            end
            if (duty_out !== prev_duty || done === 1'b1 || err === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_event duty=%0d done=%b err=%b, required no output change",
                             duty_out, done, err);
                end else begin
                    e = exp_q.pop_front();
                    if (duty_out !== 4'(e.duty) || done !== e.done || err !== e.err) begin
                        bad++;
                        $display("FAIL event duty=%0d done=%b err=%b, required duty=%0d done=%b err=%b",
                                 duty_out, done, err, e.duty, e.done, e.err);
                    end
                end
            end
            prev_duty = duty_out;
            if (finish_req) begin
                total++;
                if (exp_q.size() != 0 || timeouts != 0) begin
                    bad++;
                    $display("FAIL drain pending=%0d timeouts=%0d, required pending=0 timeouts=0",
                             exp_q.size(), timeouts);
                end
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    end

    initial begin
        bit ps;
        int tg;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Up ramp 5 -> 8, then down ramp 8 -> 2
        tick(1, 8, 0, 0, 0);
        run_idle(600);
        repeat (3) tick(0, 0, 0, 0, 0);
        tick(1, 2, 0, 0, 0);
        run_idle(1000);

        // Rejected target, then target equal to the current duty
        tick(1, 11, 0, 0, 0);
        repeat (2) tick(0, 0, 0, 0, 0);
        tick(1, 2, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        tick(1, 5, 0, 0, 0);
        run_idle(600);

        // Abort off a step edge, then on a step edge
        tick(1, 9, 0, 0, 0);
        abort_at_pulse(6, 600);
        repeat (3) tick(0, 0, 0, 0, 0);
        tick(1, 9, 0, 0, 0);
        abort_at_pulse(4, 600);
        repeat (3) tick(0, 0, 0, 0, 0);

        // Manual buttons with saturation at both ends
        tick(1, 10, 0, 0, 0);
        run_idle(600);
        tick(0, 0, 0, 1, 0);
        tick(0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            tick(0, 0, 0, 0, 1);
            tick(0, 0, 0, 0, 0);
        end
        tick(0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 1, 0);
        tick(0, 0, 0, 1, 1);

        // Buttons during a ramp are ignored
        tick(1, 7, 0, 0, 0);
        for (int i = 0; i < 800 && m_ramp; i++)
            tick(0, 0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
        run_idle(10);

        // Handshake wins over a same-cycle button
        tick(1, 7, 0, 1, 0);
        tick(0, 0, 0, 0, 0);
        tick(1, 9, 0, 1, 0);
        repeat (15) tick(0, 0, 0, 0, 0);

        // Asynchronous reset in the middle of a ramp
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        m_duty = INIT_DUTY;
        m_ramp = 1'b0;
        m_pulses = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) tick(0, 0, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            ps = ($urandom_range(0, 3) == 0);
            tg = ($urandom_range(0, 7) == 0) ? int'($urandom_range(11, 15)) : int'($urandom_range(0, 10));
            cyc(ps, $urandom_range(0, 19) == 0, tg, $urandom_range(0, 59) == 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
        end
        run_idle(2000);
        tick(0, 0, 0, 0, 0);

        finish_req = 1'b1;
        repeat (5) @(posedge clk);
        $display("FAIL finish monitor did not end the run, required summary");
        $fatal(1, "monitor did not finish");
    end

endmodule
`default_nettype wire
